// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter
//  Purpose  : Round-robin arbiter that shares the single write port of an
//             asynchronous FIFO among NUM_REQ requesters, all in the write
//             clock domain. Each grant is a bounded burst of at most
//             MAX_BURST accepted beats. An arbitration bubble (IDLE) sits
//             between bursts.
//  Ports    : w_clk      - write-domain clock
//             wrst       - asynchronous active-high reset
//             req        - per-requester level request, held while data valid
//             req_data   - requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//             gnt        - one-hot grant; beat accepted when req[i]&gnt[i]
//             full       - FIFO full flag
//             w_en       - FIFO write enable (never high while full=1)
//             data_in    - FIFO write data (0 when w_en=0)
//             owner      - current / last burst owner
//             busy       - high while in BURST
//             stat_beats - per-requester accepted-beat counters (optional)
//             stat_stall - BURST cycles stalled on full (optional)
//  Options  : `define ARB_STATS_EN to add the saturating statistics counters
//             and the stat_beats / stat_stall ports.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          w_clk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          full,
   output logic                          w_en,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic [$clog2(NUM_REQ)-1:0]    owner,
`ifdef ARB_STATS_EN
   output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_beats,
   output logic [CNT_WIDTH-1:0]          stat_stall,
`endif
   output logic                          busy
);

   localparam int OW = $clog2(NUM_REQ);
   // One extra bit so MAX_BURST-1 is representable for every legal MAX_BURST.
   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0] c_LAST_BEAT = BW'(MAX_BURST - 1);
   localparam logic [OW-1:0] c_LAST_REQ  = OW'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t          r_state;
   logic [OW-1:0]   r_owner;
   logic [OW-1:0]   r_last_owner;
   logic [BW-1:0]   r_beat_cnt;

   logic [OW-1:0]   w_sel;
   logic            w_sel_found;
   int              w_idx;
   logic            w_own_req;

   // Round-robin search starting just after the last owner.
   always_comb begin
      w_sel       = '0;
      w_sel_found = 1'b0;
      w_idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = (int'(r_last_owner) + k) % NUM_REQ;
         if (!w_sel_found && req[w_idx]) begin
            w_sel_found = 1'b1;
            w_sel       = OW'(w_idx);
         end
      end
   end

   // Grant and data mux. Grant already folds in req and ~full, so data_in is
   // automatically zero whenever no beat is accepted.
   always_comb begin
      gnt       = '0;
      data_in   = '0;
      w_own_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_owner == OW'(i)) begin
            w_own_req = req[i];
            gnt[i]    = (r_state == S_BURST) && req[i] && !full;
         end
         if (gnt[i]) begin
            data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_en  = |(gnt & req);
   assign owner = r_owner;
   assign busy  = (r_state == S_BURST);

   always_ff @(posedge w_clk or posedge wrst) begin
      if (wrst) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_last_owner <= c_LAST_REQ;
         r_beat_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sel_found) begin
                  r_owner    <= w_sel;
                  r_beat_cnt <= '0;
                  r_state    <= S_BURST;
               end
            end
            S_BURST: begin
               if (w_en) begin
                  r_beat_cnt <= r_beat_cnt + BW'(1);
                  if (r_beat_cnt == c_LAST_BEAT) begin
                     r_state      <= S_IDLE;
                     r_last_owner <= r_owner;
                  end
               end else if (!w_own_req) begin
                  // Requester released: end the burst early.
                  r_state      <= S_IDLE;
                  r_last_owner <= r_owner;
               end
               // full with req held: stall, counter and state unchanged.
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

   always_ff @(posedge w_clk or posedge wrst) begin
      if (wrst) begin
         stat_beats <= '0;
         stat_stall <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && req[i] &&
                stat_beats[i*CNT_WIDTH +: CNT_WIDTH] != c_CNT_MAX) begin
               stat_beats[i*CNT_WIDTH +: CNT_WIDTH] <=
                  stat_beats[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            end
         end
         if ((r_state == S_BURST) && full && w_own_req &&
             stat_stall != c_CNT_MAX) begin
            stat_stall <= stat_stall + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_write_arbiter
//  Purpose  : Directed self-checking bench for fifo_write_arbiter with
//             NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4. Inputs change 1 time
//             unit after the rising edge; outputs are checked a further time
//             unit later, well away from the next edge.
//  Options  : statistics checks are active when ARB_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

   logic        w_clk;
   logic        wrst;
   logic [3:0]  req;
   logic [31:0] rdata;
   logic [3:0]  gnt;
   logic        full;
   logic        w_en;
   logic [7:0]  data_in;
   logic [1:0]  owner;
   logic        busy;
`ifdef ARB_STATS_EN
   logic [63:0] stat_beats;
   logic [15:0] stat_stall;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fifo_write_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .MAX_BURST  (4),
      .CNT_WIDTH  (16)
   ) dut (
      .w_clk      (w_clk),
      .wrst       (wrst),
      .req        (req),
      .req_data   (rdata),
      .gnt        (gnt),
      .full       (full),
      .w_en       (w_en),
      .data_in    (data_in),
      .owner      (owner),
`ifdef ARB_STATS_EN
      .stat_beats (stat_beats),
      .stat_stall (stat_stall),
`endif
      .busy       (busy)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic step();
      @(posedge w_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset with all requests high ----------------
      wrst  = 1'b1;
      req   = 4'b1111;
      full  = 1'b0;
      rdata = {8'h40, 8'h30, 8'h20, 8'h10};
      step();
      step();
      #1;
      chk("rst_gnt",   32'(gnt),     32'h0);
      chk("rst_wen",   32'(w_en),    32'h0);
      chk("rst_busy",  32'(busy),    32'h0);
      chk("rst_owner", 32'(owner),   32'h0);
      chk("rst_data",  32'(data_in), 32'h0);
`ifdef ARB_STATS_EN
      chk("rst_stat_beats", 32'(stat_beats[31:0]), 32'h0);
      chk("rst_stall",      32'(stat_stall),       32'h0);
`endif
      wrst = 1'b0;
      #1;
      chk("first_idle_gnt", 32'(gnt), 32'h0);
      step();

      // ---------------- round robin, 4 beats each + 1 idle ----------------
      for (int g = 0; g < 4; g++) begin
         for (int b = 0; b < 4; b++) begin
            #1;
            chk("rr_gnt",  32'(gnt),     32'(4'b0001 << g));
            chk("rr_wen",  32'(w_en),    32'h1);
            chk("rr_data", 32'(data_in), 32'((g + 1) * 16));
            step();
         end
         #1;
         chk("rr_idle_gnt",   32'(gnt),   32'h0);
         chk("rr_idle_busy",  32'(busy),  32'h0);
         chk("rr_idle_owner", 32'(owner), 32'(g));
         if (g == 3) req = 4'b0000;
         step();
      end

      // ---------------- short burst from requester 2 ----------------
      req = 4'b0100;
      rdata[23:16] = 8'hA1;
      step();
      #1;
      chk("short_gnt",   32'(gnt),     32'h4);
      chk("short_data1", 32'(data_in), 32'hA1);
      step();
      rdata[23:16] = 8'hA2;
      #1;
      chk("short_wen2",  32'(w_en),    32'h1);
      chk("short_data2", 32'(data_in), 32'hA2);
      step();
      req = 4'b0000;
      #1;
      chk("short_drop_wen", 32'(w_en), 32'h0);
      step();
      #1;
      chk("short_busy",  32'(busy),  32'h0);
      chk("short_owner", 32'(owner), 32'h2);

      // ---------------- full stall during requester 1 ----------------
      req = 4'b0010;
      step();
      #1;
      chk("stall_b1_gnt",  32'(gnt),     32'h2);
      chk("stall_b1_data", 32'(data_in), 32'h20);
      step();
      #1;
      chk("stall_b2_wen",  32'(w_en), 32'h1);
      step();
      full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_wen",  32'(w_en), 32'h0);
         chk("stall_gnt",  32'(gnt),  32'h0);
         chk("stall_busy", 32'(busy), 32'h1);
         step();
      end
      full = 1'b0;
      #1;
      chk("stall_b3_wen", 32'(w_en), 32'h1);
      chk("stall_b3_gnt", 32'(gnt),  32'h2);
      step();
      #1;
      chk("stall_b4_wen", 32'(w_en), 32'h1);
      step();
      #1;
      chk("stall_end_busy",  32'(busy),  32'h0);
      chk("stall_end_owner", 32'(owner), 32'h1);
`ifdef ARB_STATS_EN
      chk("stat_stall", 32'(stat_stall),         32'd5);
      chk("stat_b0",    32'(stat_beats[15:0]),   32'd4);
      chk("stat_b1",    32'(stat_beats[31:16]),  32'd8);
      chk("stat_b2",    32'(stat_beats[47:32]),  32'd6);
      chk("stat_b3",    32'(stat_beats[63:48]),  32'd4);
`endif

      // ---------------- skip idle requesters ----------------
      req = 4'b0001;                       // make requester 0 the last owner
      step();
      #1;
      chk("skip_pre_gnt", 32'(gnt), 32'h1);
      step();
      req = 4'b0000;
      #1;
      chk("skip_pre_drop", 32'(gnt), 32'h0);
      step();
      #1;
      chk("skip_pre_owner", 32'(owner), 32'h0);
      req = 4'b1001;
      step();
      for (int b = 0; b < 4; b++) begin
         #1;
         chk("skip_gnt3",  32'(gnt),     32'h8);
         chk("skip_data3", 32'(data_in), 32'h40);
         step();
      end
      #1;
      chk("skip_idle_gnt",   32'(gnt),   32'h0);
      chk("skip_idle_owner", 32'(owner), 32'h3);
      step();
      #1;
      chk("skip_gnt0", 32'(gnt), 32'h1);
      req = 4'b0000;
      step();

      // ---------------- mid-burst reset on requester 3 ----------------
      req = 4'b1000;
      step();
      #1;
      chk("mid_b1_gnt", 32'(gnt), 32'h8);
      step();
      #1;
      chk("mid_b2_wen", 32'(w_en), 32'h1);
      step();
      wrst = 1'b1;
      #1;
      chk("mid_rst_wen",   32'(w_en),  32'h0);
      chk("mid_rst_gnt",   32'(gnt),   32'h0);
      chk("mid_rst_busy",  32'(busy),  32'h0);
      chk("mid_rst_owner", 32'(owner), 32'h0);
`ifdef ARB_STATS_EN
      chk("mid_rst_stall", 32'(stat_stall),        32'h0);
      chk("mid_rst_b3",    32'(stat_beats[63:48]), 32'h0);
`endif
      step();
      req  = 4'b1001;
      wrst = 1'b0;
      #1;
      chk("post_rst_idle", 32'(gnt), 32'h0);
      step();
      #1;
      chk("post_rst_gnt",   32'(gnt),   32'h1);
      chk("post_rst_owner", 32'(owner), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
